// File: rtl/bloom_query.sv
// Query side of the Bloom-filter path: owns the filter array, applies inserts/clear,
// and hashes query words serially. Optional hit/miss counters under BLOOM_QUERY_STATS_EN.
module bloom_query #(
  parameter int D_SIZE    = 32,
  parameter int HASH_SIZE = 8,
  parameter int BL_SIZE   = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 ins_valid,
  input  logic [HASH_SIZE-1:0] ins_hash,
  input  logic                 q_valid,
  output logic                 q_ready,
  input  logic [D_SIZE-1:0]    q_data,
  output logic                 r_valid,
  input  logic                 r_ready,
  output logic                 r_hit,
  output logic [15:0]          hit_cnt,
  output logic [15:0]          miss_cnt
);

  localparam int N  = D_SIZE / 5;
  localparam int IW = $clog2(BL_SIZE);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [HASH_SIZE-1:0] H_INIT  = HASH_SIZE'(5'd31);
  localparam logic [CW-1:0]        CNT_END = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, HASH, LOOKUP, RESP} state_t;

  state_t               state_q, state_d;
  logic [D_SIZE-1:0]    data_q, data_d;
  logic [HASH_SIZE-1:0] h_q, h_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 q_ready_q, q_ready_d;
  logic                 r_valid_q, r_valid_d;
  logic                 r_hit_q, r_hit_d;
  logic [BL_SIZE-1:0]   array_q, array_d;

  // One fold of the insert-side hash: (h ^ chunk) * 17, done as shift-add.
  function automatic logic [HASH_SIZE-1:0] hash_step(input logic [HASH_SIZE-1:0] h,
                                                     input logic [4:0] chunk);
    logic [HASH_SIZE-1:0] x;
    x = h ^ HASH_SIZE'(chunk);
    return (x << 4) + x;
  endfunction

  // Filter array next value; lookups read array_d so same-edge insert/clear is forwarded.
  always_comb begin
    array_d = array_q;
    if (clear) begin
      array_d = '0;
    end else if (ins_valid) begin
      array_d[ins_hash[IW-1:0]] = 1'b1;
    end else begin
      array_d = array_q;
    end
  end

  // Query FSM next-state and datapath.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    h_d       = h_q;
    cnt_d     = cnt_q;
    q_ready_d = q_ready_q;
    r_valid_d = r_valid_q;
    r_hit_d   = r_hit_q;
    case (state_q)
      IDLE: begin
        if (q_valid) begin
          data_d    = q_data;
          h_d       = H_INIT;
          cnt_d     = '0;
          q_ready_d = 1'b0;
          state_d   = HASH;
        end else begin
          q_ready_d = 1'b1;
        end
      end
      HASH: begin
        h_d    = hash_step(h_q, data_q[4:0]);
        data_d = data_q >> 3'd5;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CNT_END) begin
          state_d = LOOKUP;
        end else begin
          state_d = HASH;
        end
      end
      LOOKUP: begin
        r_hit_d   = array_d[h_q[IW-1:0]];
        r_valid_d = 1'b1;
        state_d   = RESP;
      end
      RESP: begin
        if (r_ready) begin
          r_valid_d = 1'b0;
          q_ready_d = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d   = IDLE;
        q_ready_d = 1'b1;
        r_valid_d = 1'b0;
      end
    endcase
  end

  // State, datapath and filter array registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      data_q    <= '0;
      h_q       <= '0;
      cnt_q     <= '0;
      q_ready_q <= 1'b1;
      r_valid_q <= 1'b0;
      r_hit_q   <= 1'b0;
      array_q   <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      h_q       <= h_d;
      cnt_q     <= cnt_d;
      q_ready_q <= q_ready_d;
      r_valid_q <= r_valid_d;
      r_hit_q   <= r_hit_d;
      array_q   <= array_d;
    end
  end

  assign q_ready = q_ready_q;
  assign r_valid = r_valid_q;
  assign r_hit   = r_hit_q;

`ifdef BLOOM_QUERY_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  // Saturating counters bumped once per lookup; clear does not touch them.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == LOOKUP) begin
      if (r_hit_d && (hit_cnt_q != 16'hFFFF)) begin
        hit_cnt_d = hit_cnt_q + 16'd1;
      end else if (!r_hit_d && (miss_cnt_q != 16'hFFFF)) begin
        miss_cnt_d = miss_cnt_q + 16'd1;
      end else begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
      end
    end else begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= 16'd0;
      miss_cnt_q <= 16'd0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  assign hit_cnt  = 16'h0000;
  assign miss_cnt = 16'h0000;
`endif

endmodule

// File: doc/bloom_query.md
Name: bloom_query

Overview:
- Query (reader) side of the team's Bloom-filter path. Owns the BL_SIZE-bit filter array.
- Write path: accepts pre-computed insert hashes from the hash block and sets the addressed bit.
- Read path: accepts query words, recomputes the same hash serially (one 5-bit chunk per cycle) and returns hit/miss over a valid/ready response channel.

Parameters:
- D_SIZE, 32: query data width; chunks = D_SIZE/5 (integer division); the upper D_SIZE%5 bits are ignored.
- HASH_SIZE, 8: hash accumulator width; must be >= 5.
- BL_SIZE, 256: filter array bits; power of two, <= 2**HASH_SIZE.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous clear of the whole filter array.
- ins_valid  in  1  insert strobe, one insert per cycle.
- ins_hash  in  HASH_SIZE  insert hash; bit index = ins_hash mod BL_SIZE.
- q_valid  in  1  query request valid.
- q_ready  out  1  block can accept a query.
- q_data  in  D_SIZE  query word.
- r_valid  out  1  response valid.
- r_ready  in  1  response consumer ready.
- r_hit  out  1  1 = addressed filter bit set (possible member); 0 = definite miss.
- hit_cnt  out  16  hit counter (see Optional Feature).
- miss_cnt  out  16  miss counter (see Optional Feature).

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: filter array all 0; state IDLE; q_ready=1; r_valid=0; r_hit=0; hit_cnt=0; miss_cnt=0.
- Hash, bit-exact with the insert side:
  - h starts at 31, truncated to HASH_SIZE.
  - For i = 0..N-1, with N = D_SIZE/5: h = ((h ^ zero_ext(q_data[5i+:5])) * 17) mod 2**HASH_SIZE.
  - Lookup index = h mod BL_SIZE (low log2(BL_SIZE) bits).
- FSM states: IDLE, HASH, LOOKUP, RESP.
  - IDLE: q_ready=1. On q_valid at an edge, latch q_data, set h=31, set chunk counter=0, go to HASH.
  - HASH: q_ready=0. Each edge folds chunk[counter] and increments the counter. After chunk N-1 is folded, go to LOOKUP.
  - LOOKUP: one cycle. Register r_hit = array[index], set r_valid=1, go to RESP.
  - RESP: hold r_valid and r_hit stable until r_valid & r_ready at an edge. Then clear r_valid and go to IDLE.
  - RESP never returns straight to accepting a query; q_ready is only high in IDLE.
- Latency: the acceptance edge is E0. r_valid rises after edge E0+N+1 (N=6 at defaults, so 7 cycles). Throughput is at most one query per N+3 cycles.
- Insert path is independent of the FSM:
  - ins_valid at an edge sets array[ins_hash mod BL_SIZE]=1 in any state.
  - Insert only ever sets bits; it never clears them.
- clear=1 at an edge zeroes the entire array. clear has priority over a same-edge insert.
- Forwarding: an insert or clear on the same edge as LOOKUP is visible to that lookup.
  - LOOKUP with ins_valid to the same index gives r_hit=1.
  - LOOKUP with clear=1 gives r_hit=0.
- clear during HASH or RESP does not abort the query. The response already captured in RESP is unchanged.
- q_valid outside IDLE is ignored; q_data is sampled only at acceptance.
- r_ready while r_valid=0 has no effect.
- Reset mid-query: asynchronously return to IDLE, drop the in-flight query, zero the array and counters.

Optional Feature:
- Macro: BLOOM_QUERY_STATS_EN.
- Defined: at each LOOKUP, hit_cnt increments on a hit and miss_cnt increments on a miss. Both saturate at 16'hFFFF. Both are zeroed by rst only, not by clear.
- Undefined: hit_cnt and miss_cnt are tied to 0 and no counter flops exist.

Test Plan:
- Reset, then query q_data=0 -> q_ready drops at E0; r_valid=1 after E7; r_hit=0; computed index=191 (0xBF).
- ins_hash=8'hBF, then query q_data=0 -> r_hit=1. Query q_data=32'hC000_0000 (only ignored bits set) -> r_hit=1.
- Query q_data=0 with ins_valid, ins_hash=191 on the LOOKUP edge -> r_hit=1 (forwarding). Repeat with clear=1 on that edge -> r_hit=0.
- Response backpressure: hold r_ready=0 for 5 cycles after r_valid -> r_valid and r_hit stable, q_ready=0, q_valid ignored. Raise r_ready -> r_valid drops next edge, q_ready=1.
- Assert rst during HASH -> q_ready=1 and r_valid=0 immediately (asynchronous). A previously inserted bit 191 is gone: query q_data=0 returns r_hit=0.
- BLOOM_QUERY_STATS_EN defined: 3 hits and 2 misses -> hit_cnt=3, miss_cnt=2. Pulse clear -> counts unchanged. Undefined -> both counters read 0 throughout.
